freq_bin_writer: RTL

//  Upstream feeder of the waterfall frequency BRAM. Accepts one frame of complex spectrum

---
 rtl/freq_bin_writer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/freq_bin_writer.sv
`default_nettype none
// ============================================================================
// Module   : freq_bin_writer
// Brief    : Complex spectrum bins -> alpha-max-beta-min magnitude -> BRAM
//            write port (one frame = one waterfall row), with frame_done pulse.
//            Define LOG_SCALE_EN for log-compressed output instead of the
//            linear shift/saturate.
// Revision : 1.0
// ============================================================================
module freq_bin_writer #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int IN_W     = 12,
  parameter int NUM_BINS = 512,
  parameter int SHIFT    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_re,
  input  logic signed [IN_W-1:0] s_im,
  input  logic                   s_last,
  output logic                   w_en,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [DATA_W-1:0]      w_data,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam logic [ADDR_W-1:0]      c_last_bin = ADDR_W'(NUM_BINS - 1);
  localparam logic signed [IN_W-1:0] c_most_neg = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]        c_abs_max  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]      c_data_max = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DROP  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_flush;
  logic              r_done;
  logic              r_ovf;

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [IN_W-1:0]   r_s1_re;
  logic [IN_W-1:0]   r_s1_im;

  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [DATA_W-1:0] r_s2_data;

  logic              w_accept;
  logic              w_write;
  logic [IN_W-1:0]   w_max;
  logic [IN_W-1:0]   w_min;
  logic [IN_W-1:0]   w_mag;
  logic [DATA_W-1:0] w_scaled;

  // The most-negative code has no positive twin, so it clamps to the top.
  function automatic logic [IN_W-1:0] sat_abs(input logic signed [IN_W-1:0] x);
    if (x == c_most_neg)
      return c_abs_max;
    else if (x[IN_W-1])
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  assign w_accept = s_valid & r_ready;
  assign w_write  = w_accept & ((r_state == ST_IDLE) || (r_state == ST_RUN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_flush <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (s_last) begin
              r_state <= ST_FLUSH;
              r_ready <= 1'b0;
              r_flush <= 1'b0;
            end else if (r_cnt == c_last_bin) begin
              r_state <= ST_DROP;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_DROP: begin
          if (w_accept) begin
            r_ovf <= 1'b1;
            if (s_last) begin
              r_state <= ST_FLUSH;
              r_ready <= 1'b0;
              r_flush <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_flush <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
    end else begin
      r_s1_valid <= w_write;
      r_s1_addr  <= r_cnt;
      r_s1_re    <= sat_abs(s_re);
      r_s1_im    <= sat_abs(s_im);
    end
  end

  // Both operands are at most 2**(IN_W-1)-1, so the sum fits in IN_W bits.
  assign w_max = (r_s1_re >= r_s1_im) ? r_s1_re : r_s1_im;
  assign w_min = (r_s1_re >= r_s1_im) ? r_s1_im : r_s1_re;
  assign w_mag = w_max + (w_min >> 1);

`ifdef LOG_SCALE_EN
  localparam int c_mant_w = DATA_W - 4;
  localparam int c_pos_w  = $clog2(IN_W + 1);
  localparam int c_log_w  = c_pos_w + c_mant_w + DATA_W;

  logic [c_pos_w-1:0]       w_pos;
  logic [c_pos_w-1:0]       w_lead;
  logic [IN_W+c_mant_w-1:0] w_norm;
  logic [c_log_w-1:0]       w_log;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (w_mag[i])
        w_pos = c_pos_w'(i + 1);
    end
  end

  // Shift the leading one up to bit c_mant_w; the bits beneath it are the mantissa.
  assign w_lead   = (w_pos == '0) ? '0 : w_pos - c_pos_w'(1);
  assign w_norm   = {w_mag, {c_mant_w{1'b0}}} >> w_lead;
  assign w_log    = (c_log_w'(w_pos) << c_mant_w) | c_log_w'(w_norm[c_mant_w-1:0]);
  assign w_scaled = (w_log > c_log_w'(c_data_max)) ? c_data_max : w_log[DATA_W-1:0];
`else
  localparam int                 c_wide_w   = (IN_W > DATA_W) ? IN_W : DATA_W;
  localparam logic [c_wide_w-1:0] c_sat_wide = c_wide_w'(c_data_max);

  logic [c_wide_w-1:0] w_shifted;

  assign w_shifted = c_wide_w'(w_mag) >> SHIFT;
  assign w_scaled  = (w_shifted > c_sat_wide) ? c_data_max : w_shifted[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_s2_data  <= w_scaled;
    end
  end

  assign s_ready    = r_ready;
  assign w_en       = r_s2_valid;
  assign w_addr     = r_s2_addr;
  assign w_data     = r_s2_data;
  assign frame_done = r_done;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
